hd44780_bus_receiver: RTL and testbench

Passive HD44780-side receiver for the LCD pin bus driven by `hd44780_controller`. It samples E/RS/DB7..4, tracks the panel's power-on 8-bit mode and the switch to 4-bit mode, reassembles nybble pairs into bytes, and presents each received command or data byte with a one-cycle strobe. It sits on the bench side of the LCD pins as the scoreboard front end, and on hardware as a loopback monitor for the controller's output.

---
 rtl/hd44780_pkg.sv | 19 +
 rtl/hd44780_pin_sync.sv | 26 ++
 rtl/hd44780_bus_receiver.sv | 143 ++++++++++++++
 tb/tb_hd44780_bus_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared HD44780 pin-bus definitions: receiver state encoding, error bit positions
// and the function-set patterns that switch the interface between 8-bit and 4-bit mode.
package hd44780_pkg;

  typedef enum logic [1:0] {
    StMode8 = 2'd0,
    StHi    = 2'd1,
    StLo    = 2'd2
  } rx_state_e;

  localparam int unsigned ErrShortE     = 0;
  localparam int unsigned ErrRsMismatch = 1;
  localparam int unsigned ErrTimeout    = 2;

  // Function set is 001(DL) on DB7..4; DL selects 8-bit (1) or 4-bit (0).
  localparam logic [2:0] FsDl0Nybble = 3'b001;
  localparam logic [3:0] FsDl1Nybble = 4'b0011;

endpackage

// File: rtl/hd44780_pin_sync.sv
// Two-flop synchronizer for a bundle of asynchronous LCD pins.
module hd44780_pin_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hd44780_bus_receiver.sv
// Passive HD44780-side receiver: samples E/RS/DB7..4, follows the 8-bit/4-bit mode switch
// and presents each reassembled command/data byte with a one-cycle strobe.
module hd44780_bus_receiver
  import hd44780_pkg::*;
#(
  parameter int unsigned MIN_E_HIGH = 3,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_lcd_e,
  input  logic       i_lcd_rs,
  input  logic [3:0] i_lcd_data,
  output logic       STB_O,
  output logic [7:0] o_byte,
  output logic       o_rs,
  output logic       o_four_bit,
  output logic [2:0] o_err
);

  localparam int unsigned WidthW   = $clog2(MIN_E_HIGH + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
  localparam logic [WidthW-1:0]   MinWidth    = WidthW'(MIN_E_HIGH);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);

  logic [5:0] pins_s;
  logic       e_s, rs_s;
  logic [3:0] data_s;

  hd44780_pin_sync #(
    .Width(6)
  ) u_pin_sync (
    .clk_i (CLK_I),
    .rst_ni(RST_I),
    .d_i   ({i_lcd_e, i_lcd_rs, i_lcd_data}),
    .q_o   (pins_s)
  );

  assign e_s    = pins_s[5];
  assign rs_s   = pins_s[4];
  assign data_s = pins_s[3:0];

  rx_state_e           state_q, state_d;
  logic                e_d_q;
  logic [WidthW-1:0]   width_q, width_d;
  logic [TimeoutW-1:0] to_q, to_d;
  logic [3:0]          hi_q, hi_d;
  logic                hi_rs_q, hi_rs_d;
  logic                stb_q, stb_d;
  logic [7:0]          byte_q, byte_d;
  logic                rs_q, rs_d;
  logic [2:0]          err_q, err_d;
  logic                fall, short_e, accept;

  assign fall    = e_d_q & ~e_s;
  assign short_e = fall & (width_q < MinWidth);
  assign accept  = fall & ~short_e;

  always_comb begin
    width_d = '0;
    if (e_s) begin
      width_d = (width_q == MinWidth) ? width_q : width_q + WidthW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    hi_rs_d = hi_rs_q;
    to_d    = '0;
    stb_d   = 1'b0;
    byte_d  = byte_q;
    rs_d    = rs_q;
    err_d   = '0;
    if (short_e) err_d[ErrShortE] = 1'b1;
    unique case (state_q)
      StMode8: begin
        if (accept) begin
          stb_d  = 1'b1;
          byte_d = {data_s, 4'h0};
          rs_d   = rs_s;
          if (!rs_s && data_s[3:1] == FsDl0Nybble && !data_s[0]) state_d = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = data_s;
          hi_rs_d = rs_s;
          state_d = StLo;
        end
      end
      StLo: begin
        // An accepted nybble takes priority over a timeout expiring in the same cycle.
        if (accept) begin
          stb_d  = 1'b1;
          byte_d = {hi_q, data_s};
          rs_d   = hi_rs_q;
          if (rs_s != hi_rs_q) err_d[ErrRsMismatch] = 1'b1;
          state_d = (!hi_rs_q && hi_q == FsDl1Nybble) ? StMode8 : StHi;
        end else if (to_q == TimeoutLast) begin
          err_d[ErrTimeout] = 1'b1;
          state_d           = StHi;
        end else begin
          to_d = to_q + TimeoutW'(1);
        end
      end
      default: state_d = StMode8;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= StMode8;
      e_d_q   <= 1'b0;
      width_q <= '0;
      to_q    <= '0;
      hi_q    <= 4'h0;
      hi_rs_q <= 1'b0;
      stb_q   <= 1'b0;
      byte_q  <= 8'h00;
      rs_q    <= 1'b0;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      e_d_q   <= e_s;
      width_q <= width_d;
      to_q    <= to_d;
      hi_q    <= hi_d;
      hi_rs_q <= hi_rs_d;
      stb_q   <= stb_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      err_q   <= err_d;
    end
  end

  assign STB_O      = stb_q;
  assign o_byte     = byte_q;
  assign o_rs       = rs_q;
  assign o_err      = err_q;
  assign o_four_bit = (state_q != StMode8);

endmodule

// File: tb/tb_hd44780_bus_receiver.sv
// Directed bench for hd44780_bus_receiver: init sequence, 4-bit transfers, error cases, reset.
module tb_hd44780_bus_receiver;
  import hd44780_pkg::*;

  localparam int unsigned MinEHigh = 3;
  localparam int unsigned Timeout  = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [3:0] lcd_data = 4'h0;
  logic       stb;
  logic [7:0] rx_byte;
  logic       rx_rs;
  logic       four_bit;
  logic [2:0] err;

  int n_checks = 0;
  int n_fail = 0;

  // Event log built by sampling 1 time unit after each rising edge.
  int         stb_cnt = 0;
  int         err_cnt [3] = '{0, 0, 0};
  logic [7:0] last_byte = 8'h00;
  logic       last_rs = 1'b0;
  logic       last_four = 1'b0;
  logic [2:0] last_err = 3'b000;

  hd44780_bus_receiver #(
    .MIN_E_HIGH(MinEHigh),
    .TIMEOUT   (Timeout)
  ) dut (
    .CLK_I     (clk),
    .RST_I     (rst_n),
    .i_lcd_e   (lcd_e),
    .i_lcd_rs  (lcd_rs),
    .i_lcd_data(lcd_data),
    .STB_O     (stb),
    .o_byte    (rx_byte),
    .o_rs      (rx_rs),
    .o_four_bit(four_bit),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (stb === 1'b1) begin
      stb_cnt++;
      last_byte = rx_byte;
      last_rs   = rx_rs;
      last_four = four_bit;
    end
    if (err !== 3'b000) last_err = err;
    for (int i = 0; i < 3; i++) if (err[i] === 1'b1) err_cnt[i]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic rs, input logic [3:0] d, input int hi_cycles);
    @(negedge clk);
    lcd_rs   = rs;
    lcd_data = d;
    lcd_e    = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", stb); end
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    n_checks++; if (rx_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b want 0", rx_rs); end
    n_checks++; if (four_bit !== 1'b0) begin n_fail++; $display("FAIL reset_four: got %b want 0", four_bit); end
    n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_power_on();
    int s;
    // First nybble with a cycle-exact latency check.
    @(negedge clk);
    lcd_rs = 1'b0; lcd_data = 4'h3; lcd_e = 1'b1;
    repeat (10) @(negedge clk);
    lcd_e = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (stb !== 1'b0) begin n_fail++; $display("FAIL lat_edge1: got %b want 0", stb); end
    @(posedge clk); #1;
    n_checks++; if (stb !== 1'b0) begin n_fail++; $display("FAIL lat_edge2: got %b want 0", stb); end
    @(posedge clk); #1;
    n_checks++; if (stb !== 1'b1 || rx_byte !== 8'h30) begin
      n_fail++; $display("FAIL lat_edge3: got stb %b byte %h want 1 30", stb, rx_byte);
    end
    repeat (4) @(negedge clk);
    s = stb_cnt;
    send(1'b0, 4'h3, 10);
    send(1'b0, 4'h3, 10);
    n_checks++; if (stb_cnt !== s + 2 || last_byte !== 8'h30) begin
      n_fail++; $display("FAIL init_30: got %0d strobes byte %h want %0d 30", stb_cnt - s, last_byte, 2);
    end
    n_checks++; if (four_bit !== 1'b0) begin n_fail++; $display("FAIL init_still8: got %b want 0", four_bit); end
    send(1'b0, 4'h2, 10);
    n_checks++; if (stb_cnt !== s + 3 || last_byte !== 8'h20 || last_rs !== 1'b0) begin
      n_fail++; $display("FAIL init_20: got byte %h rs %b want 20 0", last_byte, last_rs);
    end
    n_checks++; if (last_four !== 1'b1) begin n_fail++; $display("FAIL init_four_with_stb: got %b want 1", last_four); end
  endtask

  task automatic test_four_bit();
    int s;
    s = stb_cnt;
    send(1'b1, 4'h6, 10);
    n_checks++; if (stb_cnt !== s) begin n_fail++; $display("FAIL fb_no_hi_stb: got %0d want 0", stb_cnt - s); end
    send(1'b1, 4'hD, 10);
    n_checks++; if (stb_cnt !== s + 1 || last_byte !== 8'h6D || last_rs !== 1'b1) begin
      n_fail++; $display("FAIL fb_6d: got byte %h rs %b want 6d 1", last_byte, last_rs);
    end
    n_checks++; if (four_bit !== 1'b1) begin n_fail++; $display("FAIL fb_mode: got %b want 1", four_bit); end
  endtask

  task automatic test_short_e();
    int s, e0;
    s = stb_cnt; e0 = err_cnt[ErrShortE];
    send(1'b1, 4'h9, MinEHigh - 1);
    n_checks++; if (err_cnt[ErrShortE] !== e0 + 1 || last_err !== 3'b001) begin
      n_fail++; $display("FAIL short_err: got %0d pulses err %b want 1 001", err_cnt[ErrShortE] - e0, last_err);
    end
    n_checks++; if (stb_cnt !== s) begin n_fail++; $display("FAIL short_no_stb: got %0d want 0", stb_cnt - s); end
    // Exactly MIN_E_HIGH cycles is accepted.
    send(1'b1, 4'h6, MinEHigh);
    send(1'b1, 4'hD, 10);
    n_checks++; if (stb_cnt !== s + 1 || last_byte !== 8'h6D) begin
      n_fail++; $display("FAIL short_then_6d: got %0d strobes byte %h want 1 6d", stb_cnt - s, last_byte);
    end
  endtask

  task automatic test_rs_mismatch();
    int e1;
    e1 = err_cnt[ErrRsMismatch];
    send(1'b0, 4'h4, 10);
    send(1'b1, 4'h1, 10);
    n_checks++; if (last_byte !== 8'h41 || last_rs !== 1'b0) begin
      n_fail++; $display("FAIL mis_41: got byte %h rs %b want 41 0", last_byte, last_rs);
    end
    n_checks++; if (err_cnt[ErrRsMismatch] !== e1 + 1 || last_err !== 3'b010) begin
      n_fail++; $display("FAIL mis_err: got %0d pulses err %b want 1 010", err_cnt[ErrRsMismatch] - e1, last_err);
    end
    send(1'b0, 4'h3, 10);
    send(1'b0, 4'h0, 10);
    n_checks++; if (last_byte !== 8'h30 || four_bit !== 1'b0 || last_four !== 1'b0) begin
      n_fail++; $display("FAIL mode_return: got byte %h four %b want 30 0", last_byte, four_bit);
    end
  endtask

  task automatic test_timeout();
    int s, e2;
    send(1'b0, 4'h2, 10);
    n_checks++; if (last_byte !== 8'h20 || four_bit !== 1'b1) begin
      n_fail++; $display("FAIL to_enter4: got byte %h four %b want 20 1", last_byte, four_bit);
    end
    s = stb_cnt; e2 = err_cnt[ErrTimeout];
    send(1'b1, 4'hA, 10);
    // High nybble accepted 3 edges after E fell; expiry lands TIMEOUT edges later.
    repeat (Timeout - 4) @(negedge clk);
    n_checks++; if (err_cnt[ErrTimeout] !== e2) begin
      n_fail++; $display("FAIL to_early: got %0d pulses want 0", err_cnt[ErrTimeout] - e2);
    end
    @(negedge clk);
    n_checks++; if (err_cnt[ErrTimeout] !== e2 + 1 || last_err !== 3'b100) begin
      n_fail++; $display("FAIL to_err: got %0d pulses err %b want 1 100", err_cnt[ErrTimeout] - e2, last_err);
    end
    n_checks++; if (stb_cnt !== s || four_bit !== 1'b1) begin
      n_fail++; $display("FAIL to_no_stb: got %0d strobes four %b want 0 1", stb_cnt - s, four_bit);
    end
    send(1'b1, 4'h4, 10);
    send(1'b1, 4'h8, 10);
    n_checks++; if (stb_cnt !== s + 1 || last_byte !== 8'h48 || last_rs !== 1'b1) begin
      n_fail++; $display("FAIL to_48: got byte %h rs %b want 48 1", last_byte, last_rs);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 4'h7, 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (stb !== 1'b0 || rx_byte !== 8'h00 || rx_rs !== 1'b0 || four_bit !== 1'b0 || err !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset: got stb %b byte %h rs %b four %b err %b want 0 00 0 0 000",
                         stb, rx_byte, rx_rs, four_bit, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 4'h5, 10);
    n_checks++; if (last_byte !== 8'h50 || last_rs !== 1'b1 || four_bit !== 1'b0) begin
      n_fail++; $display("FAIL mid_next: got byte %h rs %b four %b want 50 1 0", last_byte, last_rs, four_bit);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_four_bit();
    test_short_e();
    test_rs_mismatch();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
